// File: rtl/csr_bank_mp.sv
// csr_bank_mp: multi-port machine/supervisor CSR storage for the multi-issue commit stage,
// with mcycle/minstret counters, registered write-drop flags and optional write->read bypass.

// csr_mapper: raw 12-bit CSR address -> storage index and writable-bit mask.
// Unmapped addresses land on index 0 with an all-zero mask, so they never hold data.
module csr_mapper #(
  parameter int XLEN        = 64,
  parameter int CYCLE_IDX   = 9,
  parameter int INSTRET_IDX = 10
) (
  input  logic [11:0]     addr,
  output logic [4:0]      idx,
  output logic [XLEN-1:0] mask
);
  localparam logic [XLEN-1:0] ONES   = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] LO32   = XLEN'(64'h0000_0000_FFFF_FFFF);
  localparam logic [XLEN-1:0] ALIGN4 = XLEN'(~64'h3);
  localparam logic [XLEN-1:0] ALIGN2 = XLEN'(~64'h1);

  always_comb begin
    idx  = 5'd0;
    mask = '0;
    case (addr)
      12'h300: begin idx = 5'd1;  mask = XLEN'(64'h0000_0000_007F_FFFF); end
      12'h100: begin idx = 5'd2;  mask = XLEN'(64'h0000_0000_000C_6122); end
      12'h302: begin idx = 5'd3;  mask = ONES;   end
      12'h303: begin idx = 5'd4;  mask = ONES;   end
      12'h304: begin idx = 5'd5;  mask = ONES;   end
      12'h305: begin idx = 5'd6;  mask = ALIGN4; end
      12'h306: begin idx = 5'd7;  mask = LO32;   end
      12'h340: begin idx = 5'd8;  mask = ONES;   end
      12'hB00: begin idx = 5'(CYCLE_IDX);   mask = ONES; end
      12'hB02: begin idx = 5'(INSTRET_IDX); mask = ONES; end
      12'h341: begin idx = 5'd11; mask = ALIGN2; end
      12'h342: begin idx = 5'd12; mask = ONES;   end
      12'h343: begin idx = 5'd13; mask = ONES;   end
      12'h344: begin idx = 5'd14; mask = ONES;   end
      12'h104: begin idx = 5'd15; mask = ONES;   end
      12'h105: begin idx = 5'd16; mask = ALIGN4; end
      12'h106: begin idx = 5'd17; mask = LO32;   end
      12'h140: begin idx = 5'd18; mask = ONES;   end
      12'h141: begin idx = 5'd19; mask = ALIGN2; end
      12'h142: begin idx = 5'd20; mask = ONES;   end
      12'h143: begin idx = 5'd21; mask = ONES;   end
      12'h144: begin idx = 5'd22; mask = ONES;   end
      12'h180: begin idx = 5'd23; mask = ONES;   end
      default: ;
    endcase
  end
endmodule

module csr_bank_mp #(
  parameter int XLEN        = 64,
  parameter int NUM_CSR     = 32,
  parameter int NUM_WR      = 3,
  parameter int NUM_RD      = 2,
  parameter int CYCLE_IDX   = 9,
  parameter int INSTRET_IDX = 10,
  parameter int BYPASS      = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_RD-1:0][11:0]           rd_addr,
  output logic [NUM_RD-1:0][XLEN-1:0]       rd_data,
  input  logic [NUM_WR-1:0]                 wr_en,
  input  logic [NUM_WR-1:0][11:0]           wr_addr,
  input  logic [NUM_WR-1:0][XLEN-1:0]       wr_data,
  input  logic [$clog2(NUM_WR+1)-1:0]       retire_cnt,
  output logic [NUM_WR-1:0]                 wr_drop,
  output logic [NUM_CSR-1:0][XLEN-1:0]      csrs
);
  localparam int          IW          = $clog2(NUM_CSR);
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_SSTATUS = 12'h100;

  logic [NUM_WR-1:0][4:0]      w_raw;
  logic [NUM_WR-1:0][IW-1:0]   w_idx;
  logic [NUM_WR-1:0][XLEN-1:0] w_mask;
  logic [NUM_WR-1:0][XLEN-1:0] w_val;
  logic [NUM_WR-1:0]           valid;
  logic [NUM_WR-1:0]           win;
  logic [NUM_RD-1:0][4:0]      r_raw;
  logic [NUM_RD-1:0][IW-1:0]   r_idx;
  logic [NUM_RD-1:0][XLEN-1:0] r_mask;
  logic [NUM_CSR-1:0][XLEN-1:0] nxt;

  // Indices the mapper produces beyond a shrunken bank fold onto the null entry.
  function automatic logic [IW-1:0] clamp_idx(input logic [4:0] raw);
    return (int'(raw) < NUM_CSR) ? raw[IW-1:0] : '0;
  endfunction

  function automatic logic [XLEN-1:0] status_fmt(input logic [XLEN-1:0] d, input logic st);
    logic [XLEN-1:0] r;
    r = d;
    if (st) r[XLEN-1] = (&d[14:13]) | (&d[16:15]) | (&d[10:9]);
    return r;
  endfunction

  for (genvar i = 0; i < NUM_WR; i++) begin : g_wmap
    csr_mapper #(.XLEN(XLEN), .CYCLE_IDX(CYCLE_IDX), .INSTRET_IDX(INSTRET_IDX)) u_map (
      .addr (wr_addr[i]),
      .idx  (w_raw[i]),
      .mask (w_mask[i])
    );
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rmap
    csr_mapper #(.XLEN(XLEN), .CYCLE_IDX(CYCLE_IDX), .INSTRET_IDX(INSTRET_IDX)) u_map (
      .addr (rd_addr[k]),
      .idx  (r_raw[k]),
      .mask (r_mask[k])
    );
  end

  // Writes are qualified by rst_n so an in-flight write cannot leak through the bypass during reset.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      w_idx[i] = clamp_idx(w_raw[i]);
      valid[i] = rst_n && wr_en[i] && (wr_addr[i] != 12'h000);
      w_val[i] = status_fmt(wr_data[i] & w_mask[i],
                            (wr_addr[i] == CSR_MSTATUS) || (wr_addr[i] == CSR_SSTATUS));
    end
  end

  // Oldest instruction wins an index; younger ports hitting the same index are dropped.
  always_comb begin
    for (int i = 0; i < NUM_WR; i++) begin
      win[i] = valid[i];
      for (int j = 0; j < i; j++) begin
        if (valid[j] && (w_idx[j] == w_idx[i])) win[i] = 1'b0;
      end
    end
  end

  always_comb begin
    nxt = csrs;
    for (int e = 0; e < NUM_CSR; e++) begin
      if (e == CYCLE_IDX)
        nxt[e] = csrs[e] + XLEN'(1);
      else if (e == INSTRET_IDX)
        nxt[e] = csrs[e] + XLEN'(retire_cnt);
      for (int i = 0; i < NUM_WR; i++) begin
        if (win[i] && (int'(w_idx[i]) == e)) nxt[e] = w_val[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csrs    <= '0;
      wr_drop <= '0;
    end else begin
      csrs    <= nxt;
      wr_drop <= valid & ~win;
    end
  end

  // Unmapped read addresses (zero mask) always return 0.
  always_comb begin
    for (int k = 0; k < NUM_RD; k++) begin
      r_idx[k]   = clamp_idx(r_raw[k]);
      rd_data[k] = csrs[r_idx[k]];
      if (BYPASS != 0) begin
        for (int i = 0; i < NUM_WR; i++) begin
          if (win[i] && (w_idx[i] == r_idx[k])) rd_data[k] = w_val[i];
        end
      end
      if (r_mask[k] == '0) rd_data[k] = '0;
    end
  end
endmodule

// File: tb/tb_csr_bank_mp.sv
// tb_csr_bank_mp: scoreboard bench for csr_bank_mp; a driver pushes expected responses from a
// behavioural CSR model, a negedge monitor pops and compares against both bypass variants.

module tb_csr_bank_mp;
  localparam int XLEN    = 64;
  localparam int NUM_CSR = 32;
  localparam int NUM_WR  = 3;
  localparam int NUM_RD  = 2;
  localparam int MCYCLE  = 9;
  localparam int MINSTRET = 10;

  logic clk = 1'b0;
  logic rst_n;
  logic [NUM_RD-1:0][11:0]      rd_addr;
  logic [NUM_RD-1:0][XLEN-1:0]  rd_data, rd_data_bp;
  logic [NUM_WR-1:0]            wr_en;
  logic [NUM_WR-1:0][11:0]      wr_addr;
  logic [NUM_WR-1:0][XLEN-1:0]  wr_data;
  logic [1:0]                   retire_cnt;
  logic [NUM_WR-1:0]            wr_drop, wr_drop_bp;
  logic [NUM_CSR-1:0][XLEN-1:0] csrs, csrs_bp;

  always #5 clk = ~clk;

  csr_bank_mp #(.XLEN(XLEN), .NUM_CSR(NUM_CSR), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                .CYCLE_IDX(MCYCLE), .INSTRET_IDX(MINSTRET), .BYPASS(0)) dut (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .retire_cnt(retire_cnt), .wr_drop(wr_drop),
    .csrs(csrs));

  csr_bank_mp #(.XLEN(XLEN), .NUM_CSR(NUM_CSR), .NUM_WR(NUM_WR), .NUM_RD(NUM_RD),
                .CYCLE_IDX(MCYCLE), .INSTRET_IDX(MINSTRET), .BYPASS(1)) dut_bp (
    .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_bp), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .retire_cnt(retire_cnt), .wr_drop(wr_drop_bp),
    .csrs(csrs_bp));

  typedef struct {
    logic [NUM_CSR-1:0][XLEN-1:0] csr;
    logic [NUM_WR-1:0]            drop;
    logic [NUM_RD-1:0][XLEN-1:0]  rd;
    logic [NUM_RD-1:0][XLEN-1:0]  rd_bp;
    int                           kind0, idx0, kind1, idx1;
    logic [XLEN-1:0]              val0, val1;
    int                           cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc_no   = 0;

  logic [XLEN-1:0] m_csr [NUM_CSR];
  logic [NUM_WR-1:0] m_drop;

  logic [11:0] addr_pool [10] = '{12'h000, 12'h300, 12'h100, 12'h340, 12'hB00,
                                  12'hB02, 12'h305, 12'h141, 12'h180, 12'h7C0};

  // Architectural address map: index and writable bits of each CSR the bench touches.
  function automatic void lookup(input logic [11:0] a, output int idx, output logic [XLEN-1:0] msk);
    idx = 0;
    msk = '0;
    case (a)
      12'h300: begin idx = 1;        msk = 64'h0000_0000_007F_FFFF; end
      12'h100: begin idx = 2;        msk = 64'h0000_0000_000C_6122; end
      12'h305: begin idx = 6;        msk = 64'hFFFF_FFFF_FFFF_FFFC; end
      12'h340: begin idx = 8;        msk = '1; end
      12'hB00: begin idx = MCYCLE;   msk = '1; end
      12'hB02: begin idx = MINSTRET; msk = '1; end
      12'h141: begin idx = 19;       msk = 64'hFFFF_FFFF_FFFF_FFFE; end
      12'h180: begin idx = 23;       msk = '1; end
      default: ;
    endcase
  endfunction

  function automatic logic sd_of(input logic [XLEN-1:0] v);
    return (v[14:13] == 2'b11) || (v[16:15] == 2'b11) || (v[10:9] == 2'b11);
  endfunction

  task automatic chk(input string name, input int cyc, input logic [XLEN-1:0] act,
                     input logic [XLEN-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_img(input string name, input int cyc,
                         input logic [NUM_CSR-1:0][XLEN-1:0] act,
                         input logic [NUM_CSR-1:0][XLEN-1:0] exp);
    int bad;
    bad = -1;
    n_checks++;
    for (int e = NUM_CSR - 1; e >= 0; e--) if (act[e] !== exp[e]) bad = e;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s cycle %0d idx %0d: got %h expected %h", name, cyc, bad, act[bad], exp[bad]);
    end
  endtask

  task automatic spot(input int cyc, input int kind, input int idx, input logic [XLEN-1:0] val);
    case (kind)
      1: chk("spot_csr", cyc, csrs[idx], val);
      2: chk("spot_wr_drop", cyc, XLEN'(wr_drop), val);
      3: chk("spot_rd0", cyc, rd_data[0], val);
      4: chk("spot_rd0_bypass", cyc, rd_data_bp[0], val);
      default: ;
    endcase
  endtask

  // Monitor: one expected response per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      chk_img("csrs", mon_e.cyc, csrs, mon_e.csr);
      chk_img("csrs_bypass", mon_e.cyc, csrs_bp, mon_e.csr);
      chk("wr_drop", mon_e.cyc, XLEN'(wr_drop), XLEN'(mon_e.drop));
      chk("wr_drop_bypass", mon_e.cyc, XLEN'(wr_drop_bp), XLEN'(mon_e.drop));
      for (int k = 0; k < NUM_RD; k++) begin
        chk("rd_data", mon_e.cyc, rd_data[k], mon_e.rd[k]);
        chk("rd_data_bypass", mon_e.cyc, rd_data_bp[k], mon_e.rd_bp[k]);
      end
      spot(mon_e.cyc, mon_e.kind0, mon_e.idx0, mon_e.val0);
      spot(mon_e.cyc, mon_e.kind1, mon_e.idx1, mon_e.val1);
    end
  end

  // Predict the response to the inputs currently applied, queue it, advance the model one edge.
  task automatic step(input int k0, input int i0, input logic [XLEN-1:0] v0,
                      input int k1, input int i1, input logic [XLEN-1:0] v1);
    exp_t            e;
    int              widx, ridx;
    logic [XLEN-1:0] msk, v;
    logic [XLEN-1:0] wval_at [NUM_CSR];
    bit              claimed [NUM_CSR];
    logic [NUM_WR-1:0] nd;
    if (!rst_n) begin
      for (int x = 0; x < NUM_CSR; x++) m_csr[x] = '0;
      m_drop = '0;
    end
    for (int x = 0; x < NUM_CSR; x++) begin
      e.csr[x]   = m_csr[x];
      claimed[x] = 1'b0;
      wval_at[x] = '0;
    end
    e.drop = m_drop;
    nd = '0;
    for (int i = 0; i < NUM_WR; i++) begin
      lookup(wr_addr[i], widx, msk);
      v = wr_data[i] & msk;
      if (wr_addr[i] == 12'h300 || wr_addr[i] == 12'h100) v[63] = sd_of(v);
      if (rst_n && wr_en[i] && wr_addr[i] != 12'h000) begin
        if (claimed[widx]) nd[i] = 1'b1;
        else begin
          claimed[widx] = 1'b1;
          wval_at[widx] = v;
        end
      end
    end
    for (int k = 0; k < NUM_RD; k++) begin
      lookup(rd_addr[k], ridx, msk);
      e.rd[k]    = m_csr[ridx];
      e.rd_bp[k] = claimed[ridx] ? wval_at[ridx] : m_csr[ridx];
    end
    if (rst_n) begin
      m_csr[MCYCLE]   = m_csr[MCYCLE] + 64'd1;
      m_csr[MINSTRET] = m_csr[MINSTRET] + 64'(retire_cnt);
      for (int x = 0; x < NUM_CSR; x++) if (claimed[x]) m_csr[x] = wval_at[x];
      m_drop = nd;
    end
    e.kind0 = k0; e.idx0 = i0; e.val0 = v0;
    e.kind1 = k1; e.idx1 = i1; e.val1 = v1;
    e.cyc   = cyc_no;
    q.push_back(e);
    cyc_no++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = '0;
    wr_addr    = '0;
    wr_data    = '0;
    retire_cnt = '0;
  endtask

  task automatic wr1(input int p, input logic [11:0] a, input logic [XLEN-1:0] d);
    wr_en[p]   = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
  endtask

  initial begin
    rst_n   = 1'b0;
    rd_addr = '0;
    idle();
    for (int x = 0; x < NUM_CSR; x++) m_csr[x] = '0;
    m_drop = '0;
    @(posedge clk);
    #1;
    step(1, MCYCLE, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Release, then mcycle counts three edges.
    rst_n = 1'b1;
    step(1, MCYCLE, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, MCYCLE, 3, 0, 0, 0);

    // Three-port conflict on mstatus; port 2 loses for one cycle only.
    wr1(0, 12'h300, 64'h2);
    wr1(1, 12'h340, 64'h55);
    wr1(2, 12'h300, 64'h8);
    step(2, 0, 0, 0, 0, 0);
    idle();
    step(2, 0, 3'b100, 1, 1, 64'h2);
    step(2, 0, 0, 1, 8, 64'h55);

    // mstatus SD summary bit.
    wr1(0, 12'h300, 64'h6000);
    step(0, 0, 0, 0, 0, 0);
    idle();
    wr1(1, 12'h300, 64'h2000);
    step(1, 1, 64'h8000_0000_0000_6000, 0, 0, 0);
    idle();
    step(1, 1, 64'h2000, 0, 0, 0);

    // mcycle write holds for the write cycle, then wraps.
    wr1(2, 12'hB00, '1);
    step(0, 0, 0, 0, 0, 0);
    idle();
    step(1, MCYCLE, '1, 0, 0, 0);
    step(1, MCYCLE, 0, 0, 0, 0);

    // minstret accumulates retire_cnt; a write overrides the same-cycle retirement.
    wr1(0, 12'hB02, 64'h0);
    step(0, 0, 0, 0, 0, 0);
    idle();
    retire_cnt = 2'd3;
    for (int c = 0; c < 4; c++) step(0, 0, 0, 0, 0, 0);
    wr1(1, 12'hB02, 64'h5);
    retire_cnt = 2'd2;
    step(1, MINSTRET, 64'd12, 0, 0, 0);
    idle();
    retire_cnt = 2'd1;
    step(1, MINSTRET, 64'd5, 0, 0, 0);
    retire_cnt = 2'd0;
    step(1, MINSTRET, 64'd6, 0, 0, 0);

    // Same-cycle write and read of mscratch.
    rd_addr[0] = 12'h340;
    rd_addr[1] = 12'hB00;
    wr1(0, 12'h340, 64'h1234);
    step(4, 0, 64'h1234, 3, 0, 64'h55);
    idle();
    step(3, 0, 64'h1234, 4, 0, 64'h1234);

    // Randomised traffic across mapped, unmapped and null addresses.
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < NUM_WR; i++) begin
        wr_en[i]   = ($urandom_range(0, 99) < 55);
        wr_addr[i] = addr_pool[$urandom_range(0, 9)];
        wr_data[i] = {$urandom(), $urandom()};
      end
      for (int k = 0; k < NUM_RD; k++) rd_addr[k] = addr_pool[$urandom_range(0, 9)];
      retire_cnt = 2'($urandom_range(0, 3));
      step(0, 0, 0, 0, 0, 0);
    end

    // Reset asserted between edges while writes (and a pending drop) are in flight.
    wr1(0, 12'h340, 64'hAAAA);
    wr1(1, 12'h340, 64'hBBBB);
    wr1(2, 12'h340, 64'hCCCC);
    step(0, 0, 0, 0, 0, 0);
    wr1(0, 12'h300, 64'h6000);
    wr1(1, 12'hB00, 64'h77);
    wr1(2, 12'h300, 64'h1);
    rd_addr[0] = 12'h300;
    rst_n = 1'b0;
    step(2, 0, 0, 4, 0, 0);
    step(1, MCYCLE, 0, 1, 1, 0);
    idle();
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, MCYCLE, 3, 2, 0, 0);

    for (int t = 0; t < 4 && q.size() != 0; t++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d responses still queued, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
